// File: rtl/core_pkg.sv
// Shared RV32I core types: datapath width, load/store funct3 encodings and the
// EX/MEM pipeline bundle.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
  } exmem_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory stage: store lane replication and
// byte enables, and load lane extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] load_value
);

  logic [XLEN-1:0] rdata_shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Load path: misaligned halves simply use off[1].
  always_comb begin
    rdata_shifted = rdata >> {off, 3'b000};
    byte_sel      = rdata_shifted[7:0];
    half_sel      = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_value = {24'h0, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_value = {16'h0, half_sel};
      default: load_value = rdata;
    endcase
  end

  always_comb begin
    wdata = store_data;
    be    = 4'b0000;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << off;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << {off[1], 1'b0};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory access stage;
// stalls upstream while the data memory inserts wait states.
module ex_mem_wb_pipe
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      exmem_rd,
  output logic            exmem_reg_write,
  output logic            exmem_is_load,
  output logic [XLEN-1:0] exmem_fwd_data,
  output logic [4:0]      memwb_rd,
  output logic            memwb_reg_write,
  output logic [XLEN-1:0] memwb_wdata
);

  exmem_t          exmem_q, exmem_d;
  logic            memwb_valid_q, memwb_valid_d;
  logic [4:0]      memwb_rd_q, memwb_rd_d;
  logic            memwb_reg_write_q, memwb_reg_write_d;
  logic [XLEN-1:0] memwb_wdata_q, memwb_wdata_d;

  logic            mem_access;
  logic            mem_stall;
  logic [XLEN-1:0] lsu_wdata;
  logic [3:0]      lsu_be;
  logic [XLEN-1:0] load_value;

  lsu_align u_lsu_align (
    .funct3     (exmem_q.funct3),
    .off        (exmem_q.alu_result[1:0]),
    .store_data (exmem_q.store_data),
    .rdata      (dmem_rdata),
    .wdata      (lsu_wdata),
    .be         (lsu_be),
    .load_value (load_value)
  );

  always_comb begin
    mem_access = exmem_q.valid & (exmem_q.mem_read | exmem_q.mem_write);
    mem_stall  = mem_access & ~dmem_ready;
  end

  // A stalled MEM stage holds EX/MEM and feeds a bubble into MEM/WB.
  always_comb begin
    exmem_d           = exmem_q;
    memwb_valid_d     = 1'b0;
    memwb_rd_d        = memwb_rd_q;
    memwb_reg_write_d = memwb_reg_write_q;
    memwb_wdata_d     = memwb_wdata_q;
    if (!mem_stall) begin
      exmem_d.valid      = ex_valid;
      exmem_d.rd         = ex_rd;
      exmem_d.reg_write  = ex_reg_write;
      exmem_d.mem_read   = ex_mem_read;
      exmem_d.mem_write  = ex_mem_write;
      exmem_d.funct3     = ex_funct3;
      exmem_d.alu_result = ex_alu_result;
      exmem_d.store_data = ex_store_data;
      memwb_valid_d      = exmem_q.valid;
      memwb_rd_d         = exmem_q.rd;
      memwb_reg_write_d  = exmem_q.reg_write;
      memwb_wdata_d      = exmem_q.mem_read ? load_value : exmem_q.alu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_q           <= '0;
      memwb_valid_q     <= 1'b0;
      memwb_rd_q        <= 5'd0;
      memwb_reg_write_q <= 1'b0;
      memwb_wdata_q     <= '0;
    end else begin
      exmem_q           <= exmem_d;
      memwb_valid_q     <= memwb_valid_d;
      memwb_rd_q        <= memwb_rd_d;
      memwb_reg_write_q <= memwb_reg_write_d;
      memwb_wdata_q     <= memwb_wdata_d;
    end
  end

  // Memory-side signals derive only from EX/MEM, so they stay stable while stalled.
  always_comb begin
    stall_out       = mem_stall;
    dmem_req        = mem_access;
    dmem_we         = exmem_q.valid & exmem_q.mem_write;
    dmem_addr       = {exmem_q.alu_result[XLEN-1:2], 2'b00};
    dmem_wdata      = mem_access ? lsu_wdata : '0;
    dmem_be         = dmem_we ? lsu_be : 4'b0000;
    exmem_rd        = exmem_q.rd;
    exmem_reg_write = exmem_q.valid & exmem_q.reg_write;
    exmem_is_load   = exmem_q.valid & exmem_q.mem_read;
    exmem_fwd_data  = exmem_q.alu_result;
    memwb_rd        = memwb_rd_q;
    memwb_reg_write = memwb_valid_q & memwb_reg_write_q;
    memwb_wdata     = memwb_wdata_q;
  end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe: ALU writeback, load stalls, load/store
// alignment, back-to-back hazards and reset during a stall.
module tb_ex_mem_wb_pipe;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        stall_out, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, exmem_is_load, memwb_reg_write;
  logic [31:0] exmem_fwd_data, memwb_wdata;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  ex_mem_wb_pipe dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .exmem_is_load(exmem_is_load), .exmem_fwd_data(exmem_fwd_data),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_wdata(memwb_wdata)
  );

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] sd);
    ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
    ex_mem_write = mw; ex_funct3 = f3; ex_alu_result = alu; ex_store_data = sd;
  endtask

  task automatic bubble();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [160:0] all_out;
    rst = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    drive_ex(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, F3_W, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); step();
    all_out = {stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, exmem_rd,
               exmem_reg_write, exmem_is_load, exmem_fwd_data, memwb_rd, memwb_reg_write,
               memwb_wdata};
    nvec++; if (all_out !== '0) begin nerr++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    bubble();
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    drive_ex(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0);
    step();
    bubble();
    nvec++; if ({exmem_reg_write, exmem_rd} !== {1'b1, 5'd5}) begin nerr++; $display("FAIL alu_exmem_tag: got %b/%0d want 1/5", exmem_reg_write, exmem_rd); end
    nvec++; if (exmem_fwd_data !== 32'h0000_1234) begin nerr++; $display("FAIL alu_exmem_fwd: got %h want 00001234", exmem_fwd_data); end
    nvec++; if (memwb_reg_write !== 1'b0) begin nerr++; $display("FAIL alu_memwb_early: got %b want 0", memwb_reg_write); end
    step();
    nvec++; if ({memwb_reg_write, memwb_rd, memwb_wdata} !== {1'b1, 5'd5, 32'h0000_1234}) begin nerr++; $display("FAIL alu_wb: got %b/%0d/%h want 1/5/00001234", memwb_reg_write, memwb_rd, memwb_wdata); end
    nvec++; if (exmem_reg_write !== 1'b0) begin nerr++; $display("FAIL alu_exmem_drain: got %b want 0", exmem_reg_write); end
  endtask

  task automatic test_lw_stall();
    int stalls = 0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    drive_ex(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
    step();
    bubble();
    if (stall_out) stalls++;
    nvec++; if ({dmem_req, dmem_we, dmem_addr, exmem_is_load} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin nerr++; $display("FAIL lw_req: got req=%b we=%b addr=%h ld=%b want 1 0 00000100 1", dmem_req, dmem_we, dmem_addr, exmem_is_load); end
    step();
    if (stall_out) stalls++;
    nvec++; if (dmem_addr !== 32'h0000_0100) begin nerr++; $display("FAIL lw_addr_held: got %h want 00000100", dmem_addr); end
    nvec++; if (memwb_reg_write !== 1'b0) begin nerr++; $display("FAIL lw_bubble1: got %b want 0", memwb_reg_write); end
    step();
    nvec++; if (memwb_reg_write !== 1'b0) begin nerr++; $display("FAIL lw_bubble2: got %b want 0", memwb_reg_write); end
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    if (stall_out) stalls++;
    nvec++; if (stalls != 2) begin nerr++; $display("FAIL lw_stall_cycles: got %0d want 2", stalls); end
    step();
    nvec++; if ({memwb_reg_write, memwb_rd, memwb_wdata} !== {1'b1, 5'd6, 32'hDEAD_BEEF}) begin nerr++; $display("FAIL lw_wb: got %b/%0d/%h want 1/6/deadbeef", memwb_reg_write, memwb_rd, memwb_wdata); end
  endtask

  task automatic test_load_align();
    dmem_ready = 1'b1; dmem_rdata = 32'h80FF_FF7F;
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0);
    step();
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'h0);
    step();
    nvec++; if (memwb_wdata !== 32'hFFFF_FF80) begin nerr++; $display("FAIL lb: got %h want ffffff80", memwb_wdata); end
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, F3_H, 32'h0000_0102, 32'h0);
    step();
    nvec++; if (memwb_wdata !== 32'h0000_0080) begin nerr++; $display("FAIL lbu: got %h want 00000080", memwb_wdata); end
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0);
    step();
    nvec++; if (memwb_wdata !== 32'hFFFF_80FF) begin nerr++; $display("FAIL lh: got %h want ffff80ff", memwb_wdata); end
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0101, 32'h0);
    step();
    nvec++; if (memwb_wdata !== 32'h0000_80FF) begin nerr++; $display("FAIL lhu: got %h want 000080ff", memwb_wdata); end
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, F3_B, 32'h0000_0101, 32'h0);
    step();
    nvec++; if (memwb_wdata !== 32'h80FF_FF7F) begin nerr++; $display("FAIL ld_other_f3: got %h want 80ffff7f", memwb_wdata); end
    bubble();
    step();
    nvec++; if (memwb_wdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL lb_lane1: got %h want ffffffff", memwb_wdata); end
  endtask

  task automatic test_store_align();
    dmem_ready = 1'b1;
    drive_ex(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, F3_B, 32'h0000_0202, 32'h1234_56AB);
    step();
    nvec++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 4'b0100, 32'h200, 32'hABAB_ABAB}) begin nerr++; $display("FAIL sb: got req=%b we=%b be=%b addr=%h wd=%h", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata); end
    drive_ex(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, F3_H, 32'h0000_0206, 32'hCAFE_1234);
    step();
    nvec++; if (memwb_reg_write !== 1'b0) begin nerr++; $display("FAIL sb_no_wb: got %b want 0", memwb_reg_write); end
    nvec++; if ({dmem_be, dmem_addr, dmem_wdata} !== {4'b1100, 32'h204, 32'h1234_1234}) begin nerr++; $display("FAIL sh: got be=%b addr=%h wd=%h", dmem_be, dmem_addr, dmem_wdata); end
    drive_ex(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, F3_W, 32'h0000_0033, 32'h89AB_CDEF);
    step();
    bubble();
    nvec++; if ({dmem_be, dmem_addr, dmem_wdata} !== {4'b1111, 32'h30, 32'h89AB_CDEF}) begin nerr++; $display("FAIL sw: got be=%b addr=%h wd=%h", dmem_be, dmem_addr, dmem_wdata); end
    step();
    nvec++; if ({dmem_req, dmem_we, dmem_be} !== {1'b0, 1'b0, 4'b0000}) begin nerr++; $display("FAIL idle_mem: got req=%b we=%b be=%b", dmem_req, dmem_we, dmem_be); end
  endtask

  task automatic test_back_to_back();
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    drive_ex(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0040, 32'h0);
    step();
    drive_ex(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0);
    nvec++; if (stall_out !== 1'b1) begin nerr++; $display("FAIL b2b_stall: got %b want 1", stall_out); end
    step();
    nvec++; if ({exmem_rd, exmem_is_load, memwb_reg_write} !== {5'd8, 1'b1, 1'b0}) begin nerr++; $display("FAIL b2b_hold: got rd=%0d ld=%b wb=%b want 8 1 0", exmem_rd, exmem_is_load, memwb_reg_write); end
    dmem_ready = 1'b1; dmem_rdata = 32'h1122_3344;
    step();
    bubble();
    nvec++; if ({memwb_reg_write, memwb_rd, memwb_wdata} !== {1'b1, 5'd8, 32'h1122_3344}) begin nerr++; $display("FAIL b2b_load_wb: got %b/%0d/%h want 1/8/11223344", memwb_reg_write, memwb_rd, memwb_wdata); end
    nvec++; if ({exmem_reg_write, exmem_rd, exmem_fwd_data} !== {1'b1, 5'd9, 32'h55}) begin nerr++; $display("FAIL b2b_add_exmem: got %b/%0d/%h want 1/9/00000055", exmem_reg_write, exmem_rd, exmem_fwd_data); end
    step();
    nvec++; if ({memwb_reg_write, memwb_rd, memwb_wdata} !== {1'b1, 5'd9, 32'h55}) begin nerr++; $display("FAIL b2b_add_wb: got %b/%0d/%h want 1/9/00000055", memwb_reg_write, memwb_rd, memwb_wdata); end
    step();
    nvec++; if (memwb_reg_write !== 1'b0) begin nerr++; $display("FAIL b2b_no_dup: got %b want 0", memwb_reg_write); end
  endtask

  task automatic test_reset_mid_stall();
    dmem_ready = 1'b0;
    drive_ex(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0080, 32'h0);
    step();
    bubble();
    nvec++; if (stall_out !== 1'b1) begin nerr++; $display("FAIL rst_pre_stall: got %b want 1", stall_out); end
    #2 rst = 1'b1;
    #1;
    nvec++; if ({stall_out, dmem_req, dmem_addr, exmem_reg_write, exmem_is_load, memwb_reg_write} !== '0) begin nerr++; $display("FAIL rst_mid_stall: stall=%b req=%b addr=%h exrw=%b ld=%b wbrw=%b", stall_out, dmem_req, dmem_addr, exmem_reg_write, exmem_is_load, memwb_reg_write); end
    #1 rst = 1'b0;
    dmem_ready = 1'b1;
    step();
    drive_ex(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0077, 32'h0);
    step();
    bubble();
    step();
    nvec++; if ({memwb_reg_write, memwb_rd, memwb_wdata} !== {1'b1, 5'd3, 32'h77}) begin nerr++; $display("FAIL rst_recover: got %b/%0d/%h want 1/3/00000077", memwb_reg_write, memwb_rd, memwb_wdata); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_stall();
    test_load_align();
    test_store_align();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
